// File: rtl/sync_debouncer.sv
// Two-part input conditioner: a SYNC_STAGES-deep synchronizer followed by a
// four-state debounce FSM. Define SYNC_DEBOUNCER_GLITCH_CNT_EN to add glitch_cnt.
module sync_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_raw,
  output logic       a,
  output logic       busy
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   a_q, busy_q;

  assign s    = sync_q[SYNC_STAGES-1];
  assign a    = a_q;
  assign busy = busy_q;

  // cnt_d counts edges on which s already held the target value; it is
  // cleared on every entry to a STABLE_* state so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_HI;
          end else begin
            state_d = PEND_HI;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_LO;
          end else begin
            state_d = PEND_LO;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], a_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Outputs decode the next state so they move on the same edge as it.
      a_q     <= (state_d == STABLE_HI) || (state_d == PEND_LO);
      busy_q  <= (state_d == PEND_HI) || (state_d == PEND_LO);
    end
  end

`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;
  logic       rejected;

  // A pending transition abandoned because s returned to the old level.
  assign rejected = ((state_q == PEND_HI) && !s) || ((state_q == PEND_LO) && s);

  always_comb begin
    glitch_d = glitch_q;
    if (rejected && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= 8'd0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_sync_debouncer.sv
// Self-checking bench for sync_debouncer: default configuration plus a
// SYNC_STAGES=3 / STABLE_CYCLES=1 copy, both checked against a run-length model.
module tb_sync_debouncer;

  localparam int NM = 2;

  logic clk = 1'b0;
  logic rst;
  logic a_raw;
  logic a, busy, a1, busy1;
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
  logic [7:0] glitch_cnt, glitch_cnt1;
`endif

  always #5 clk = ~clk;

  sync_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .a_raw (a_raw),
    .a     (a),
    .busy  (busy)
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  sync_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .a_raw (a_raw),
    .a     (a1),
    .busy  (busy1)
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt1)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: s is a_raw delayed by SYNC_STAGES edges (0 right after
  // reset); a flips once s has differed from a for STABLE_CYCLES edges in a row.
  int sc [NM] = '{4, 1};
  int ss [NM] = '{2, 3};
  bit raw_hist [$];
  bit m_a    [NM];
  bit m_busy [NM];
  int m_run  [NM];
  int m_gl   [NM];

  bit det_en = 1'b0;
  bit a_prev = 1'b0;
  int rises  = 0;
  int hi_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_s(input int i);
    int idx;
    idx = raw_hist.size() - ss[i] - 1;
    return (idx >= 0) ? raw_hist[idx] : 1'b0;
  endfunction

  task automatic model_edge(input bit r);
    bit s;
    if (r) begin
      raw_hist.delete();
      for (int i = 0; i < NM; i++) begin
        m_a[i] = 1'b0; m_busy[i] = 1'b0; m_run[i] = 0; m_gl[i] = 0;
      end
    end else begin
      raw_hist.push_back(a_raw);
      for (int i = 0; i < NM; i++) begin
        s = model_s(i);
        if (s != m_a[i]) begin
          m_run[i]++;
          if (m_run[i] == sc[i]) begin
            m_a[i]   = s;
            m_run[i] = 0;
          end
        end else begin
          if (m_run[i] > 0 && m_gl[i] < 255) m_gl[i]++;
          m_run[i] = 0;
        end
        m_busy[i] = (m_run[i] > 0);
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic tick(input bit raw, input bit r);
    a_raw = raw;
    rst   = r;
    @(posedge clk);
    model_edge(r);
    #1;
    chk("a", 32'(a), int'(m_a[0]));
    chk("busy", 32'(busy), int'(m_busy[0]));
    chk("a_cfg2", 32'(a1), int'(m_a[1]));
    chk("busy_cfg2", 32'(busy1), int'(m_busy[1]));
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    chk("glitch_cnt", 32'(glitch_cnt), m_gl[0]);
    chk("glitch_cnt_cfg2", 32'(glitch_cnt1), m_gl[1]);
`endif
    if (det_en) begin
      if (a === 1'b1 && a_prev == 1'b0) rises++;
      if (a === 1'b1) begin
        hi_len++;
      end else if (a_prev) begin
        chk("t5_pulse_width_ok", 32'(hi_len >= 4), 1);
        hi_len = 0;
      end
    end
    a_prev = (a === 1'b1);
  endtask

  bit pat3 [10] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1};
  logic [15:0] seq5 = 16'b1000111001000100;

  initial begin
    int busy_cycles;
    a_raw = 1'b0;
    rst   = 1'b1;

    // Reset state
    tick(1'b0, 1'b1);
    chk("rst_a", 32'(a), 0);
    chk("rst_busy", 32'(busy), 0);

    // 1 and 6: step to 1 right after reset release
    for (int e = 1; e <= 12; e++) begin
      tick(1'b1, 1'b0);
      chk("t1_a", 32'(a), (e >= 6) ? 1 : 0);
      chk("t1_busy", 32'(busy), (e >= 3 && e <= 5) ? 1 : 0);
      chk("t6_a", 32'(a1), (e >= 4) ? 1 : 0);
      chk("t6_busy", 32'(busy1), 0);
    end

    // 2: three-cycle low glitch while a=1
    busy_cycles = 0;
    for (int e = 1; e <= 12; e++) begin
      tick((e <= 3) ? 1'b0 : 1'b1, 1'b0);
      chk("t2_a", 32'(a), 1);
      if (busy === 1'b1) busy_cycles++;
    end
    chk("t2_busy_cycles", 32'(busy_cycles), 3);
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    chk("t2_glitch_cnt", 32'(glitch_cnt), 1);
`endif

    // 3: bouncing rise, a follows only the final run
    for (int e = 1; e <= 10; e++) tick(1'b0, 1'b0);
    chk("t3_pre_a", 32'(a), 0);
    for (int e = 1; e <= 14; e++) begin
      tick((e <= 10) ? pat3[e-1] : 1'b1, 1'b0);
      chk("t3_a", 32'(a), (e >= 10) ? 1 : 0);
    end

    // 4: reset during PEND_HI, then a rises 6 edges after release
    for (int e = 1; e <= 10; e++) tick(1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) tick(1'b1, 1'b0);
    chk("t4_pend_busy", 32'(busy), 1);
    tick(1'b1, 1'b1);
    chk("t4_rst_a", 32'(a), 0);
    chk("t4_rst_busy", 32'(busy), 0);
    for (int e = 1; e <= 8; e++) begin
      tick(1'b1, 1'b0);
      chk("t4_a", 32'(a), (e >= 6) ? 1 : 0);
    end
    tick(1'b1, 1'b1);
    chk("t4_rst_from_hi_a", 32'(a), 0);

    // 5: edge detector downstream of a, starting from a=1
    for (int e = 1; e <= 10; e++) tick(1'b1, 1'b0);
    chk("t5_pre_a", 32'(a), 1);
    det_en = 1'b1;
    rises  = 0;
    hi_len = 0;
    for (int b = 15; b >= 0; b--) begin
      for (int c = 0; c < 8; c++) tick(seq5[b], 1'b0);
    end
    for (int c = 0; c < 8; c++) tick(1'b0, 1'b0);
    det_en = 1'b0;
    chk("t5_rises", 32'(rises), 3);

    // Random runs with occasional resets
    for (int n = 0; n < 800; ) begin
      bit v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        tick(v, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
      n += len;
    end

`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    // Saturation of the glitch counter
    tick(1'b0, 1'b1);
    for (int e = 1; e <= 10; e++) tick(1'b0, 1'b0);
    for (int g = 0; g < 260; g++) begin
      tick(1'b1, 1'b0);
      for (int j = 0; j < 3; j++) tick(1'b0, 1'b0);
    end
    chk("glitch_sat", 32'(glitch_cnt), 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_debouncer.md
Name: sync_debouncer

Overview:
- Input-conditioning stage directly upstream of the posedge / one-cycle-pulse detectors.
- Takes an asynchronous, possibly bouncing level `a_raw`, synchronizes it into `clk`, and filters glitches.
- Drives a clean level `a`, which changes only after the synchronized input has held a new value for `STABLE_CYCLES` consecutive cycles.
- The detectors connect directly to `a` with no glue logic.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchronizer chain; legal values are >= 2.
- STABLE_CYCLES, 4, number of consecutive cycles a new synchronized value must hold before `a` follows; legal values are >= 1.
- CNT_W, $clog2(STABLE_CYCLES)+1, width of the stability counter; derived value, must not be overridden.

Ports:
- clk  input  1  clock; all logic is clocked on posedge.
- rst  input  1  reset; synchronous, active-high.
- a_raw  input  1  raw asynchronous input level.
- a  output  1  debounced, synchronized level; registered output.
- busy  output  1  1 while a transition is pending (PEND_HI / PEND_LO); registered output.

Behaviour:
- Reset:
  - Synchronous and active-high; it dominates all other logic.
  - On any posedge with rst=1: sync chain = 0, state = STABLE_LO, counter = 0, a = 0, busy = 0.
  - Outputs are undefined until the first posedge with rst=1.
- Synchronizer:
  - SYNC_STAGES flops in series; `s` is the last stage.
  - No logic between stages.
- FSM states: STABLE_LO (a=0), PEND_HI (a=0), STABLE_HI (a=1), PEND_LO (a=1).
- STABLE_LO:
  - s=1 -> PEND_HI with cnt=1.
  - If STABLE_CYCLES=1, s=1 -> STABLE_HI directly.
  - Otherwise, stay.
- PEND_HI:
  - s=0 -> STABLE_LO (glitch rejected).
  - s=1 and cnt==STABLE_CYCLES-1 -> STABLE_HI.
  - Otherwise, cnt++.
- STABLE_HI and PEND_LO: mirror STABLE_LO and PEND_HI with 0/1 swapped.
- Outputs:
  - a = 1 in STABLE_HI and PEND_LO.
  - busy = 1 in PEND_HI and PEND_LO.
  - Both are registered and derived from the next state, so they change on the same edge as the state.
- Latency:
  - With a_raw held constant from before sampling edge 1, a changes at edge SYNC_STAGES+STABLE_CYCLES.
  - Defaults: edge 6.
- Glitch rejection:
  - Any s pulse shorter than STABLE_CYCLES cycles never reaches a.
  - busy still asserts for the pulse duration (delayed by SYNC_STAGES).
- Simultaneous events:
  - s toggling back on the exact edge where cnt would complete counts as a glitch, not a transition.
  - The transition requires s equal to the target value on all STABLE_CYCLES edges.
- Counter: never wraps. It is bounded by STABLE_CYCLES-1 and cleared on every STABLE_* entry.
- Reset mid-operation: a pending transition is discarded, and a returns to 0 on the reset edge even if it was 1.
- Output profile: a produces no combinational path from a_raw, and has no pulse narrower than STABLE_CYCLES cycles.

Optional Feature:
- Macro: SYNC_DEBOUNCER_GLITCH_CNT_EN.
- Defined:
  - Adds output `glitch_cnt` (8 bits), a saturating count of rejected glitches.
  - It increments on every PEND_HI->STABLE_LO and PEND_LO->STABLE_HI transition.
  - It holds at 255; reset sets it to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Defaults, after reset release: drive a_raw=1 and hold 12 cycles -> a=0 through edge 5 and a=1 from edge 6; busy=1 at edges 3-5 only.
2. With a=1 stable: drive a_raw=0 for 3 cycles, then back to 1 -> a stays 1, busy pulses 3 cycles. With the macro defined, glitch_cnt goes 0->1.
3. Drive a_raw pattern 1,0,1,0,1,1,1,1,1,1 -> a rises only after the final run: edge 6 counted from the first 1 of that run (edge 10 overall).
4. Assert rst while in PEND_HI (cnt=2), then release with a_raw=1 held -> a=0 and busy=0 on the reset edge; a rises 6 edges after release.
5. Chain a -> posedge_detector using the 16-bit sequence 1000111001000100, each bit held 8 cycles -> detector sees exactly 3 rising edges and no spurious pulses.
6. STABLE_CYCLES=1, SYNC_STAGES=3: step a_raw 0->1 -> a=1 at edge 4; busy stays 0 throughout.
